// File: rtl/burst_int_gen.sv
// Interrupter window generator: periodic gate-enable pulse with duty clamp and clean stop.
// Define BURST_INT_GEN_BURST_EN to add burst mode (N firing periods, M silent periods).
module burst_int_gen #(
   parameter int CLK_MHZ     = 100,
   parameter int PAR_MAX_VAL = 255,
   parameter int K1          = 20,
   parameter int K2          = 15,
   parameter int K3          = 9,
   parameter int BURST_MAX   = 15
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic [$clog2(PAR_MAX_VAL+1)-1:0]   freq_par,
   input  logic [$clog2(PAR_MAX_VAL+1)-1:0]   pw_par,
   input  logic [$clog2(BURST_MAX+1)-1:0]     burst_on,
   input  logic [$clog2(BURST_MAX+1)-1:0]     burst_off,
   output logic                               out,
   output logic                               period_start,
   output logic                               busy
);

   localparam int PW    = $clog2(PAR_MAX_VAL + 1);
   localparam int P_MAX = (1 << K1) + (PAR_MAX_VAL << K2);
   localparam int CW    = $clog2(P_MAX);
   localparam int LW    = ((CW + 1) > (PW + K3)) ? (CW + 1) : (PW + K3);
   localparam int unused_clk_mhz = CLK_MHZ;

`ifdef BURST_INT_GEN_BURST_EN
   localparam int BW = $clog2(BURST_MAX + 1);
   typedef enum logic [1:0] {IDLE, RUN, STOP, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
`endif

   function automatic logic [LW-1:0] period_of(input logic [PW-1:0] f);
      return (LW'(1) << K1) + (LW'(f) << K2);
   endfunction

   // On-time is never allowed past half the period, whatever pw asks for.
   function automatic logic [LW-1:0] on_len_of(input logic [PW-1:0] f, input logic [PW-1:0] w);
      logic [LW-1:0] raw;
      logic [LW-1:0] half;
      raw  = LW'(w) << K3;
      half = period_of(f) >> 1;
      return (raw < half) ? raw : half;
   endfunction

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [PW-1:0]   freq_sh, freq_n;
   logic [PW-1:0]   pw_sh, pw_n;
   logic            ps_q, ps_n;
   logic            stop_fire_q, stop_fire_n;
   logic            load;
   logic            fire;

`ifdef BURST_INT_GEN_BURST_EN
   logic [BW-1:0]   bon_sh, bon_n;
   logic [BW-1:0]   boff_sh, boff_n;
   logic [BW-1:0]   bcnt_q, bcnt_n;
   logic [BW:0]     bcnt_inc;
   logic [BW:0]     eff_bon;

   assign bcnt_inc = {1'b0, bcnt_q} + (BW+1)'(1);
   assign eff_bon  = (bon_sh == '0) ? (BW+1)'(1) : {1'b0, bon_sh};
`else
   logic            unused_burst;
   assign unused_burst = ^{burst_on, burst_off};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         freq_sh     <= '0;
         pw_sh       <= '0;
         ps_q        <= 1'b0;
         stop_fire_q <= 1'b0;
`ifdef BURST_INT_GEN_BURST_EN
         bon_sh      <= '0;
         boff_sh     <= '0;
         bcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         freq_sh     <= freq_n;
         pw_sh       <= pw_n;
         ps_q        <= ps_n;
         stop_fire_q <= stop_fire_n;
`ifdef BURST_INT_GEN_BURST_EN
         bon_sh      <= bon_n;
         boff_sh     <= boff_n;
         bcnt_q      <= bcnt_n;
`endif
      end
   end

   // A stop only takes effect at a period boundary; en seen high there resumes firing.
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      freq_n      = freq_sh;
      pw_n        = pw_sh;
      ps_n        = 1'b0;
      stop_fire_n = stop_fire_q;
      load        = 1'b0;
`ifdef BURST_INT_GEN_BURST_EN
      bon_n       = bon_sh;
      boff_n      = boff_sh;
      bcnt_n      = bcnt_q;
`endif
      if (state_q == IDLE) begin
         cnt_n = '0;
         if (en) begin
            state_n = RUN;
            load    = 1'b1;
`ifdef BURST_INT_GEN_BURST_EN
            bcnt_n  = '0;
`endif
         end
      end else if (cnt_q == '0) begin
         if (!en) begin
            state_n = IDLE;
         end else begin
            load    = 1'b1;
            state_n = RUN;
`ifdef BURST_INT_GEN_BURST_EN
            bcnt_n  = '0;
            if (state_q == RUN && bcnt_inc < eff_bon) begin
               bcnt_n = bcnt_inc[BW-1:0];
            end else if (state_q == RUN && boff_sh != '0) begin
               state_n = GAP;
            end else if (state_q == GAP && bcnt_inc < {1'b0, boff_sh}) begin
               state_n = GAP;
               bcnt_n  = bcnt_inc[BW-1:0];
            end
`endif
         end
      end else begin
         cnt_n = cnt_q - CW'(1);
         if (!en && state_q != STOP) begin
            state_n     = STOP;
            stop_fire_n = (state_q == RUN);
         end
      end
      if (load) begin
         freq_n = freq_par;
         pw_n   = pw_par;
         cnt_n  = CW'(period_of(freq_par) - LW'(1));
         ps_n   = 1'b1;
`ifdef BURST_INT_GEN_BURST_EN
         bon_n  = burst_on;
         boff_n = burst_off;
`endif
      end
   end

   assign fire         = (state_q == RUN) || (state_q == STOP && stop_fire_q);
   assign out          = fire && (LW'(cnt_q) < on_len_of(freq_sh, pw_sh));
   assign period_start = ps_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_burst_int_gen.sv
// Directed bench for burst_int_gen with K1=4, K2=1, K3=1, so P = 16 + 2*freq_par.
// Burst-pattern expectations follow BURST_INT_GEN_BURST_EN when the bench is compiled.
module tb_burst_int_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] freq_par = '0;
   logic [7:0] pw_par = '0;
   logic [3:0] burst_on = '0;
   logic [3:0] burst_off = '0;
   logic       out;
   logic       period_start;
   logic       busy;

   int errors = 0;
   int checks = 0;

   burst_int_gen #(
      .CLK_MHZ(100), .PAR_MAX_VAL(255), .K1(4), .K2(1), .K3(1), .BURST_MAX(15)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .freq_par(freq_par), .pw_par(pw_par),
      .burst_on(burst_on), .burst_off(burst_off),
      .out(out), .period_start(period_start), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic e, input logic [7:0] f, input logic [7:0] w,
                                input logic [3:0] bon, input logic [3:0] boff);
      en        = e;
      freq_par  = f;
      pw_par    = w;
      burst_on  = bon;
      burst_off = boff;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance until the next period_start, returning how many cycles that took.
   task automatic waitPeriodStart(output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!period_start && n < 1000);
   endtask

   // Starting on a period_start cycle, profile one period up to the next strobe.
   task automatic measurePeriod(output int len, output int high, output int first);
      len   = 0;
      high  = 0;
      first = -1;
      do begin
         if (out) begin
            high++;
            if (first < 0) first = len;
         end
         len++;
         tick(1);
      end while (!period_start && len < 1000);
   endtask

   initial begin : main
      int n, len, high, first, busy_cycles, busy_high;
      int exp_high[6];

      $display("[TB] start");
      applyStimulus(1'b0, 8'd0, 8'd0, 4'd0, 4'd0);
      tick(2);
      checkOutput("reset_out", out, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ps", period_start, 0);
      rst = 1'b0;
      tick(3);
      checkOutput("idle_busy", busy, 0);

      applyStimulus(1'b1, 8'd2, 8'd3, 4'd0, 4'd0);
      tick(1);
      checkOutput("en_ps", period_start, 1);
      checkOutput("en_busy", busy, 1);
      measurePeriod(len, high, first);
      checkOutput("p20_len", len, 20);
      checkOutput("p20_high", high, 6);
      checkOutput("p20_first", first, 14);
      measurePeriod(len, high, first);
      checkOutput("p20b_len", len, 20);
      checkOutput("p20b_high", high, 6);

      tick(5);
      applyStimulus(1'b1, 8'd5, 8'd3, 4'd0, 4'd0);
      waitPeriodStart(n);
      checkOutput("midchg_rest", n, 15);
      measurePeriod(len, high, first);
      checkOutput("p26_len", len, 26);
      checkOutput("p26_high", high, 6);
      checkOutput("p26_first", first, 20);

      applyStimulus(1'b1, 8'd0, 8'd255, 4'd0, 4'd0);
      waitPeriodStart(n);
      checkOutput("clamp_prev_len", n, 26);
      measurePeriod(len, high, first);
      checkOutput("clamp_len", len, 16);
      checkOutput("clamp_high", high, 8);
      checkOutput("clamp_first", first, 8);

      applyStimulus(1'b1, 8'd0, 8'd0, 4'd0, 4'd0);
      waitPeriodStart(n);
      checkOutput("pw0_prev_len", n, 16);
      measurePeriod(len, high, first);
      checkOutput("pw0_len", len, 16);
      checkOutput("pw0_high", high, 0);
      checkOutput("pw0_busy", busy, 1);

      applyStimulus(1'b1, 8'd2, 8'd3, 4'd0, 4'd0);
      waitPeriodStart(n);
      checkOutput("stop_prev_len", n, 16);
      tick(15);
      checkOutput("stop_out_before", out, 1);
      en = 1'b0;
      busy_cycles = 0;
      busy_high = 0;
      while (busy && busy_cycles < 100) begin
         if (out) busy_high++;
         busy_cycles++;
         tick(1);
      end
      checkOutput("stop_tail_busy", busy_cycles, 5);
      checkOutput("stop_tail_high", busy_high, 5);
      checkOutput("stop_idle_out", out, 0);
      checkOutput("stop_idle_ps", period_start, 0);

      en = 1'b1;
      tick(1);
      checkOutput("reen_ps", period_start, 1);
      tick(3);
      en = 1'b0;
      tick(2);
      checkOutput("cancel_busy", busy, 1);
      en = 1'b1;
      waitPeriodStart(n);
      checkOutput("cancel_rest", n, 15);
      measurePeriod(len, high, first);
      checkOutput("cancel_len", len, 20);
      checkOutput("cancel_high", high, 6);

      applyStimulus(1'b1, 8'd2, 8'd3, 4'd2, 4'd3);
`ifdef BURST_INT_GEN_BURST_EN
      exp_high = '{6, 6, 0, 0, 0, 6};
`else
      exp_high = '{6, 6, 6, 6, 6, 6};
`endif
      waitPeriodStart(n);
      checkOutput("burst_prev_len", n, 20);
      for (int i = 0; i < 6; i++) begin
         measurePeriod(len, high, first);
         checkOutput($sformatf("burst_len_%0d", i), len, 20);
         checkOutput($sformatf("burst_high_%0d", i), high, exp_high[i]);
      end

      tick(16);
      checkOutput("rst_pre_out", out, 1);
      rst = 1'b1;
      en = 1'b0;
      tick(1);
      checkOutput("rst_out", out, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ps", period_start, 0);
      rst = 1'b0;
      tick(3);
      checkOutput("rst_hold_busy", busy, 0);
      checkOutput("rst_hold_out", out, 0);
      applyStimulus(1'b1, 8'd0, 8'd255, 4'd0, 4'd0);
      tick(1);
      checkOutput("rst_reen_ps", period_start, 1);
      measurePeriod(len, high, first);
      checkOutput("rst_reen_len", len, 16);
      checkOutput("rst_reen_high", high, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
